// File: rtl/smem_req_issuer_pkg.sv
// Shared types and sizing for the shared-memory request issuer.
// Holds the pending-entry layout, issue FSM states and a lane-mask helper.
package smem_req_issuer_pkg;

  localparam int unsigned NUM_REQS    = 4;
  localparam int unsigned WORD_SIZE   = 4;
  localparam int unsigned ADDR_WIDTH  = 30;
  localparam int unsigned MAX_PENDING = 4;
  localparam int unsigned UUID_WIDTH  = 8;
  localparam int unsigned TAG_WIDTH   = $clog2(MAX_PENDING);
  localparam int unsigned WORD_BITS   = 8 * WORD_SIZE;
  localparam int unsigned DATA_WIDTH  = NUM_REQS * WORD_BITS;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } issue_state_e;

  typedef struct packed {
    logic                  valid;
    logic [UUID_WIDTH-1:0] uuid;
    logic [NUM_REQS-1:0]   exp_mask;
    logic [NUM_REQS-1:0]   recv_mask;
    logic [DATA_WIDTH-1:0] data;
  } pend_entry_t;

  // Widen a per-lane mask into a per-bit data mask.
  function automatic logic [DATA_WIDTH-1:0] lane_expand(input logic [NUM_REQS-1:0] m);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      r[i*WORD_BITS +: WORD_BITS] = {WORD_BITS{m[i]}};
    end
    return r;
  endfunction

endpackage

// File: rtl/smem_req_issuer_if.sv
// Bus bundles for the issuer: LSU-facing request/response and memory-facing
// per-lane request/batched response. master = initiator side of each bus.
interface smem_lsu_if;
  import smem_req_issuer_pkg::*;

  logic                           req_valid;
  logic                           req_rw;
  logic [NUM_REQS-1:0]            req_tmask;
  logic [NUM_REQS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQS*WORD_SIZE-1:0]  req_byteen;
  logic [DATA_WIDTH-1:0]          req_data;
  logic [UUID_WIDTH-1:0]          req_uuid;
  logic                           req_ready;
  logic                           rsp_valid;
  logic [NUM_REQS-1:0]            rsp_tmask;
  logic [DATA_WIDTH-1:0]          rsp_data;
  logic [UUID_WIDTH-1:0]          rsp_uuid;
  logic                           rsp_ready;

  modport master (
    output req_valid, req_rw, req_tmask, req_addr, req_byteen, req_data, req_uuid,
    input  req_ready,
    input  rsp_valid, rsp_tmask, rsp_data, rsp_uuid,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_rw, req_tmask, req_addr, req_byteen, req_data, req_uuid,
    output req_ready,
    output rsp_valid, rsp_tmask, rsp_data, rsp_uuid,
    input  rsp_ready
  );
endinterface

interface smem_core_if;
  import smem_req_issuer_pkg::*;

  logic [NUM_REQS-1:0]            core_req_valid;
  logic [NUM_REQS-1:0]            core_req_rw;
  logic [NUM_REQS*ADDR_WIDTH-1:0] core_req_addr;
  logic [NUM_REQS*WORD_SIZE-1:0]  core_req_byteen;
  logic [DATA_WIDTH-1:0]          core_req_data;
  logic [NUM_REQS*TAG_WIDTH-1:0]  core_req_tag;
  logic [NUM_REQS-1:0]            core_req_ready;
  logic                           core_rsp_valid;
  logic [NUM_REQS-1:0]            core_rsp_tmask;
  logic [DATA_WIDTH-1:0]          core_rsp_data;
  logic [TAG_WIDTH-1:0]           core_rsp_tag;
  logic                           core_rsp_ready;

  modport master (
    output core_req_valid, core_req_rw, core_req_addr, core_req_byteen, core_req_data, core_req_tag,
    input  core_req_ready,
    input  core_rsp_valid, core_rsp_tmask, core_rsp_data, core_rsp_tag,
    output core_rsp_ready
  );

  modport slave (
    input  core_req_valid, core_req_rw, core_req_addr, core_req_byteen, core_req_data, core_req_tag,
    output core_req_ready,
    output core_rsp_valid, core_rsp_tmask, core_rsp_data, core_rsp_tag,
    input  core_rsp_ready
  );
endinterface

// File: rtl/smem_pending_table.sv
// Outstanding-load table: lowest-free allocation, per-tag response merge,
// and completion detection. An entry is freed on the edge it completes.
module smem_pending_table
  import smem_req_issuer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  alloc_en,
  input  logic [UUID_WIDTH-1:0] alloc_uuid,
  input  logic [NUM_REQS-1:0]   alloc_mask,
  output logic [TAG_WIDTH-1:0]  alloc_tag,
  output logic                  full,
  input  logic                  rsp_fire,
  input  logic [TAG_WIDTH-1:0]  rsp_tag,
  input  logic [NUM_REQS-1:0]   rsp_tmask,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  done_c,
  output logic [NUM_REQS-1:0]   done_tmask_c,
  output logic [DATA_WIDTH-1:0] done_data_c,
  output logic [UUID_WIDTH-1:0] done_uuid_c
);

  pend_entry_t              entries [MAX_PENDING];
  pend_entry_t              hit;
  logic [MAX_PENDING-1:0]   free_mask;
  logic [NUM_REQS-1:0]      recv_next;
  logic [DATA_WIDTH-1:0]    merged;
  logic                     rsp_ok;
  logic                     found;

  // Free mask comes straight from registered valid bits.
  always_comb begin
    free_mask = '0;
    alloc_tag = '0;
    found     = 1'b0;
    for (int i = 0; i < int'(MAX_PENDING); i++) begin
      free_mask[i] = ~entries[i].valid;
      if (!found && free_mask[i]) begin
        alloc_tag = TAG_WIDTH'(i);
        found     = 1'b1;
      end
    end
  end

  assign full = ~found;

  // Merge the incoming beat into the addressed entry.
  always_comb begin
    hit          = entries[rsp_tag];
    recv_next    = hit.recv_mask | rsp_tmask;
    rsp_ok       = hit.valid && ((rsp_tmask & ~hit.exp_mask) == '0);
    merged       = (hit.data & ~lane_expand(rsp_tmask)) | (rsp_data & lane_expand(rsp_tmask));
    done_c       = rsp_fire && rsp_ok && (recv_next == hit.exp_mask);
    done_tmask_c = hit.exp_mask;
    done_data_c  = merged;
    done_uuid_c  = hit.uuid;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(MAX_PENDING); i++) begin
        entries[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(MAX_PENDING); i++) begin
        if (alloc_en && (alloc_tag == TAG_WIDTH'(i))) begin
          entries[i] <= '{valid: 1'b1, uuid: alloc_uuid, exp_mask: alloc_mask,
                          recv_mask: '0, data: '0};
        end else if (rsp_fire && rsp_ok && (rsp_tag == TAG_WIDTH'(i))) begin
          entries[i].valid     <= ~done_c;
          entries[i].recv_mask <= recv_next;
          entries[i].data      <= merged;
        end
      end
    end
  end

  // Responses must target a live entry and stay within its expected lanes.
  assert property (@(posedge clk) disable iff (!reset_n) rsp_fire |-> rsp_ok);

endmodule

// File: rtl/smem_req_issuer.sv
// Core-side shared-memory initiator: issues warp-wide requests lane by lane,
// retries refused lanes, and returns merged load responses upstream.
module smem_req_issuer
  import smem_req_issuer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  smem_lsu_if.slave  lsu,
  smem_core_if.master core
);

  issue_state_e                   state_q, state_d;
  logic [NUM_REQS-1:0]            rem_q, rem_d;
  logic                           rw_q;
  logic [NUM_REQS-1:0]            tmask_q;
  logic [NUM_REQS*ADDR_WIDTH-1:0] addr_q;
  logic [NUM_REQS*WORD_SIZE-1:0]  byteen_q;
  logic [DATA_WIDTH-1:0]          data_q;
  logic [TAG_WIDTH-1:0]           tag_q;

  logic                           req_ready_c;
  logic                           accept;
  logic                           alloc_en;
  logic [TAG_WIDTH-1:0]           alloc_tag;
  logic                           full;

  logic                           core_rsp_ready_c;
  logic                           core_rsp_fire;
  logic                           done_c;
  logic [NUM_REQS-1:0]            done_tmask_c;
  logic [DATA_WIDTH-1:0]          done_data_c;
  logic [UUID_WIDTH-1:0]          done_uuid_c;

  logic                           rsp_valid_q;
  logic [NUM_REQS-1:0]            rsp_tmask_q;
  logic [DATA_WIDTH-1:0]          rsp_data_q;
  logic [UUID_WIDTH-1:0]          rsp_uuid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept && (lsu.req_tmask != '0)) state_d = ISSUE;
      ISSUE: if (rem_d == '0) state_d = IDLE;
    endcase
  end

  // Accept logic and remaining-lane update.
  always_comb begin
    req_ready_c = 1'b0;
    accept      = 1'b0;
    alloc_en    = 1'b0;
    rem_d       = rem_q;
    case (state_q)
      IDLE: begin
        req_ready_c = reset_n && (lsu.req_rw || (lsu.req_tmask == '0) || !full);
        accept      = req_ready_c && lsu.req_valid;
        alloc_en    = accept && !lsu.req_rw && (lsu.req_tmask != '0);
        if (accept) rem_d = lsu.req_tmask;
      end
      ISSUE: rem_d = rem_q & ~(rem_q & core.core_req_ready);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q    <= '0;
      rw_q     <= 1'b0;
      tmask_q  <= '0;
      addr_q   <= '0;
      byteen_q <= '0;
      data_q   <= '0;
      tag_q    <= '0;
    end else begin
      rem_q <= rem_d;
      if (accept) begin
        rw_q     <= lsu.req_rw;
        tmask_q  <= lsu.req_tmask;
        addr_q   <= lsu.req_addr;
        byteen_q <= lsu.req_byteen;
        data_q   <= lsu.req_data;
        tag_q    <= alloc_tag;
      end
    end
  end

  assign lsu.req_ready        = req_ready_c;
  assign core.core_req_valid  = rem_q;
  assign core.core_req_rw     = tmask_q & {NUM_REQS{rw_q}};
  assign core.core_req_addr   = addr_q;
  assign core.core_req_byteen = byteen_q;
  assign core.core_req_data   = data_q;
  assign core.core_req_tag    = {NUM_REQS{tag_q}};

  assign core_rsp_ready_c    = reset_n && (!rsp_valid_q || lsu.rsp_ready);
  assign core_rsp_fire       = core.core_rsp_valid && core_rsp_ready_c;
  assign core.core_rsp_ready = core_rsp_ready_c;

  smem_pending_table u_table (
    .clk          (clk),
    .reset_n      (reset_n),
    .alloc_en     (alloc_en),
    .alloc_uuid   (lsu.req_uuid),
    .alloc_mask   (lsu.req_tmask),
    .alloc_tag    (alloc_tag),
    .full         (full),
    .rsp_fire     (core_rsp_fire),
    .rsp_tag      (core.core_rsp_tag),
    .rsp_tmask    (core.core_rsp_tmask),
    .rsp_data     (core.core_rsp_data),
    .done_c       (done_c),
    .done_tmask_c (done_tmask_c),
    .done_data_c  (done_data_c),
    .done_uuid_c  (done_uuid_c)
  );

  // Upstream output register; a completion may refill it on the draining edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_tmask_q <= '0;
      rsp_data_q  <= '0;
      rsp_uuid_q  <= '0;
    end else if (done_c) begin
      rsp_valid_q <= 1'b1;
      rsp_tmask_q <= done_tmask_c;
      rsp_data_q  <= done_data_c;
      rsp_uuid_q  <= done_uuid_c;
    end else if (rsp_valid_q && lsu.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign lsu.rsp_valid = rsp_valid_q;
  assign lsu.rsp_tmask = rsp_tmask_q;
  assign lsu.rsp_data  = rsp_data_q;
  assign lsu.rsp_uuid  = rsp_uuid_q;

endmodule

// File: tb/tb_smem_req_issuer.sv
// Scoreboard bench for smem_req_issuer: directed loads/stores, a reference
// model of the pending table, and an upstream response monitor.
module tb_smem_req_issuer;
  import smem_req_issuer_pkg::*;

  logic clk = 1'b0;
  logic reset_n;

  smem_lsu_if  lsu_bus ();
  smem_core_if core_bus ();

  smem_req_issuer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .lsu     (lsu_bus),
    .core    (core_bus)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0]   uuid;
    logic [3:0]   tmask;
    logic [127:0] data;
  } exp_t;

  exp_t         exp_q[$];
  logic         m_valid [4];
  logic [7:0]   m_uuid  [4];
  logic [3:0]   m_exp   [4];
  logic [3:0]   m_recv  [4];
  logic [127:0] m_data  [4];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] lmask(input logic [3:0] m);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = m[i] ? 32'hFFFF_FFFF : 32'h0;
    return r;
  endfunction

  function automatic logic [119:0] mk_addr(input logic [29:0] base);
    return {base + 30'd3, base + 30'd2, base + 30'd1, base};
  endfunction

  function automatic logic [127:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Present one upstream request; checks the first issue cycle.
  task automatic send_req(input logic rw, input logic [3:0] tm, input logic [7:0] uuid,
                          input logic [119:0] addr, input logic [127:0] data, output int tag);
    int   n  = 0;
    logic ok = 1'b0;
    tag = -1;
    lsu_bus.req_valid  = 1'b1;
    lsu_bus.req_rw     = rw;
    lsu_bus.req_tmask  = tm;
    lsu_bus.req_uuid   = uuid;
    lsu_bus.req_addr   = addr;
    lsu_bus.req_data   = data;
    lsu_bus.req_byteen = 16'hF3C5;
    while (!ok && n < 50) begin
      #1;
      if (lsu_bus.req_ready) ok = 1'b1;
      else begin @(negedge clk); n++; end
    end
    if (!ok) begin
      chk("req_accept_timeout", 128'(0), 128'(1));
      lsu_bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (!rw && tm != 4'b0) begin
      for (int i = 3; i >= 0; i--) if (!m_valid[i]) tag = i;
      if (tag < 0) chk("model_alloc", 128'(0), 128'(1));
      else begin
        m_valid[tag] = 1'b1; m_uuid[tag] = uuid; m_exp[tag] = tm;
        m_recv[tag] = 4'b0;  m_data[tag] = '0;
      end
    end
    @(negedge clk);
    lsu_bus.req_valid = 1'b0;
    #1;
    if (tm != 4'b0) begin
      chk("issue_valid",  128'(core_bus.core_req_valid), 128'(tm));
      chk("issue_rw",     128'(core_bus.core_req_rw), 128'(rw ? tm : 4'b0));
      chk("issue_addr",   128'(core_bus.core_req_addr), 128'(addr));
      chk("issue_data",   core_bus.core_req_data, data);
      chk("issue_byteen", 128'(core_bus.core_req_byteen), 128'(16'hF3C5));
      if (tag >= 0) chk("issue_tag", 128'(core_bus.core_req_tag), 128'({4{2'(tag)}}));
    end else begin
      chk("drop_valid", 128'(core_bus.core_req_valid), 128'(0));
    end
  endtask

  // One memory response beat; model merges it and queues a completion.
  task automatic mem_rsp(input int t, input logic [3:0] tm, input logic [127:0] d);
    int   n  = 0;
    logic ok = 1'b0;
    core_bus.core_rsp_valid = 1'b1;
    core_bus.core_rsp_tag   = 2'(t);
    core_bus.core_rsp_tmask = tm;
    core_bus.core_rsp_data  = d;
    while (!ok && n < 50) begin
      #1;
      if (core_bus.core_rsp_ready) ok = 1'b1;
      else begin @(negedge clk); n++; end
    end
    if (!ok) begin
      chk("core_rsp_timeout", 128'(0), 128'(1));
      core_bus.core_rsp_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) if (tm[i]) m_data[t][i*32 +: 32] = d[i*32 +: 32];
    m_recv[t] = m_recv[t] | tm;
    if (m_valid[t] && m_recv[t] == m_exp[t]) begin
      exp_q.push_back('{uuid: m_uuid[t], tmask: m_exp[t], data: m_data[t]});
      m_valid[t] = 1'b0;
    end
    @(negedge clk);
    core_bus.core_rsp_valid = 1'b0;
  endtask

  // Upstream monitor: compare each fired response against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #5;
      if (reset_n && lsu_bus.rsp_valid && lsu_bus.rsp_ready) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 128'(1), 128'(0));
        else begin
          e = exp_q.pop_front();
          chk("rsp_uuid",  128'(lsu_bus.rsp_uuid), 128'(e.uuid));
          chk("rsp_tmask", 128'(lsu_bus.rsp_tmask), 128'(e.tmask));
          chk("rsp_data",  lsu_bus.rsp_data & lmask(e.tmask), e.data & lmask(e.tmask));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    int           tg;
    logic [127:0] d;
    reset_n = 1'b0;
    lsu_bus.req_valid = 1'b0; lsu_bus.req_rw = 1'b0; lsu_bus.req_tmask = '0;
    lsu_bus.req_addr = '0; lsu_bus.req_byteen = '0; lsu_bus.req_data = '0;
    lsu_bus.req_uuid = '0; lsu_bus.rsp_ready = 1'b1;
    core_bus.core_req_ready = 4'b1111; core_bus.core_rsp_valid = 1'b0;
    core_bus.core_rsp_tmask = '0; core_bus.core_rsp_data = '0; core_bus.core_rsp_tag = '0;
    model_clear();

    idle(3);
    chk("rst_req_ready",      128'(lsu_bus.req_ready), 128'(0));
    chk("rst_core_req_valid", 128'(core_bus.core_req_valid), 128'(0));
    chk("rst_core_rsp_ready", 128'(core_bus.core_rsp_ready), 128'(0));
    chk("rst_rsp_valid",      128'(lsu_bus.rsp_valid), 128'(0));
    reset_n = 1'b1;
    idle(2);

    // Full-warp load answered in one beat.
    d = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
    send_req(1'b0, 4'b1111, 8'h21, mk_addr(30'h100), rnd_data(), tg);
    chk("t1_tag", 128'(tg), 128'(0));
    mem_rsp(0, 4'b1111, d);
    #1;
    chk("t1_rsp_valid", 128'(lsu_bus.rsp_valid), 128'(1));
    idle(2);

    // Partial acceptance then two partial responses.
    core_bus.core_req_ready = 4'b0001;
    send_req(1'b0, 4'b1011, 8'h42, mk_addr(30'h200), rnd_data(), tg);
    chk("t2_tag_reuse", 128'(tg), 128'(0));
    @(posedge clk); @(negedge clk); #1;
    chk("t2_retry_valid", 128'(core_bus.core_req_valid), 128'(4'b1010));
    core_bus.core_req_ready = 4'b1010;
    @(posedge clk); @(negedge clk); #1;
    chk("t2_done_valid", 128'(core_bus.core_req_valid), 128'(0));
    chk("t2_idle_ready", 128'(lsu_bus.req_ready), 128'(1));
    core_bus.core_req_ready = 4'b1111;
    mem_rsp(0, 4'b0001, rnd_data());
    #1;
    chk("t2_partial_no_rsp", 128'(lsu_bus.rsp_valid), 128'(0));
    mem_rsp(0, 4'b1010, rnd_data());
    idle(2);

    // Fill the table, then free tag 2 and reuse it.
    for (int i = 0; i < 4; i++) begin
      send_req(1'b0, 4'b1111, 8'(8'h30 + i), mk_addr(30'(i * 16)), rnd_data(), tg);
      chk("t3_fill_tag", 128'(tg), 128'(i));
    end
    idle(2);
    lsu_bus.req_valid = 1'b1; lsu_bus.req_rw = 1'b0; lsu_bus.req_tmask = 4'b1111;
    #1;
    chk("t3_full_ready", 128'(lsu_bus.req_ready), 128'(0));
    mem_rsp(2, 4'b1111, rnd_data());
    #1;
    chk("t3_freed_ready", 128'(lsu_bus.req_ready), 128'(1));
    send_req(1'b0, 4'b1111, 8'h34, mk_addr(30'h300), rnd_data(), tg);
    chk("t3_realloc_tag", 128'(tg), 128'(2));
    mem_rsp(0, 4'b1111, rnd_data());
    mem_rsp(3, 4'b1111, rnd_data());
    mem_rsp(1, 4'b1111, rnd_data());
    mem_rsp(2, 4'b1111, rnd_data());
    idle(2);

    // Store and empty-mask load produce no entry and no response.
    send_req(1'b1, 4'b0110, 8'h50, mk_addr(30'h400), rnd_data(), tg);
    idle(2);
    send_req(1'b0, 4'b0000, 8'h51, mk_addr(30'h500), rnd_data(), tg);
    idle(2);

    // Out-of-order completion with a stalled upstream.
    lsu_bus.rsp_ready = 1'b0;
    send_req(1'b0, 4'b1111, 8'h60, mk_addr(30'h600), rnd_data(), tg);
    chk("t5_tag0", 128'(tg), 128'(0));
    send_req(1'b0, 4'b0011, 8'h61, mk_addr(30'h700), rnd_data(), tg);
    chk("t5_tag1", 128'(tg), 128'(1));
    mem_rsp(1, 4'b0011, rnd_data());
    #1;
    chk("t5_rsp_valid",   128'(lsu_bus.rsp_valid), 128'(1));
    chk("t5_stall_ready", 128'(core_bus.core_rsp_ready), 128'(0));
    idle(2);
    chk("t5_hold_uuid",   128'(lsu_bus.rsp_uuid), 128'(8'h61));
    chk("t5_hold_ready",  128'(core_bus.core_rsp_ready), 128'(0));
    lsu_bus.rsp_ready = 1'b1;
    mem_rsp(0, 4'b1111, rnd_data());
    idle(3);

    // Reset while a store is stuck issuing and two loads are pending.
    send_req(1'b0, 4'b1111, 8'h70, mk_addr(30'h800), rnd_data(), tg);
    send_req(1'b0, 4'b1111, 8'h71, mk_addr(30'h900), rnd_data(), tg);
    idle(1);
    core_bus.core_req_ready = 4'b0000;
    send_req(1'b1, 4'b1111, 8'h72, mk_addr(30'hA00), rnd_data(), tg);
    idle(1);
    chk("t6_stuck_valid", 128'(core_bus.core_req_valid), 128'(4'b1111));
    reset_n = 1'b0;
    #1;
    chk("t6_rst_req_ready",      128'(lsu_bus.req_ready), 128'(0));
    chk("t6_rst_core_req_valid", 128'(core_bus.core_req_valid), 128'(0));
    chk("t6_rst_core_rsp_ready", 128'(core_bus.core_rsp_ready), 128'(0));
    chk("t6_rst_rsp_valid",      128'(lsu_bus.rsp_valid), 128'(0));
    model_clear();
    idle(2);
    reset_n = 1'b1;
    core_bus.core_req_ready = 4'b1111;
    idle(1);
    send_req(1'b0, 4'b0101, 8'h73, mk_addr(30'hB00), rnd_data(), tg);
    chk("t6_post_rst_tag", 128'(tg), 128'(0));
    mem_rsp(0, 4'b0101, rnd_data());
    idle(4);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
